// File: rtl/char_motion.sv
// char_motion: per-frame platformer character motion with a gravity/jump FSM.
// Optional air (double) jump is enabled by defining CHAR_DOUBLE_JUMP_EN.
module char_motion #(
  parameter int X_START = 320,
  parameter int Y_START = 300,
  parameter int SIZE    = 8,
  parameter int X_STEP  = 2,
  parameter int JUMP_V  = 10,
  parameter int G_MAX   = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic       top_collide,
  input  logic       bottom_collide,
  input  logic       left_collide,
  input  logic       right_collide,
  output logic [9:0] Char_X_Pos,
  output logic [9:0] Char_Y_Pos,
  output logic [9:0] Char_X_Motion,
  output logic [9:0] Char_Y_Motion,
  output logic [9:0] Char_Size,
  output logic       on_ground
);

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;

  localparam logic signed [11:0] X_LO = 12'(SIZE);
  localparam logic signed [11:0] X_HI = 12'(639 - SIZE);
  localparam logic signed [11:0] Y_LO = 12'(SIZE);
  localparam logic signed [11:0] Y_HI = 12'(479 - SIZE);

  localparam logic [9:0]        X_STEP_P = 10'(X_STEP);
  localparam logic [9:0]        X_STEP_N = 10'(-X_STEP);
  localparam logic [9:0]        JUMP_N   = 10'(-JUMP_V);
  localparam logic signed [9:0] G_MAX_S  = 10'(G_MAX);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

  state_t state, state_next, state_mot;

  logic frame_clk_d, tick, jump_prev;
  logic a_held, d_held, w_held, jump_req;
  logic [9:0] x_motion_next, x_pos_next;
  logic [9:0] y_inc, y_motion_fsm, y_motion_next, y_pos_next;
  logic signed [11:0] x_sum, y_sum;

`ifdef CHAR_DOUBLE_JUMP_EN
  logic air_jump, air_jump_use;
`endif

  assign a_held   = (keycode0 == KEY_A) || (keycode1 == KEY_A);
  assign d_held   = (keycode0 == KEY_D) || (keycode1 == KEY_D);
  assign w_held   = (keycode0 == KEY_W) || (keycode1 == KEY_W);
  assign tick     = frame_clk & ~frame_clk_d;
  assign jump_req = w_held & ~jump_prev;

  assign Char_Size = 10'(SIZE);

  // Horizontal velocity and clamped position
  always_comb begin
    x_motion_next = '0;
    if (a_held && !left_collide)
      x_motion_next = X_STEP_N;
    else if (d_held && !right_collide)
      x_motion_next = X_STEP_P;
    x_sum = $signed({2'b00, Char_X_Pos}) + $signed({{2{x_motion_next[9]}}, x_motion_next});
    if (x_sum < X_LO)
      x_pos_next = X_LO[9:0];
    else if (x_sum > X_HI)
      x_pos_next = X_HI[9:0];
    else
      x_pos_next = x_sum[9:0];
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      state <= FALL;
    else if (tick)
      state <= state_next;
  end

  // Next state, vertical velocity and clamped vertical position
  always_comb begin
    state_mot    = state;
    y_motion_fsm = Char_Y_Motion;
    y_inc        = Char_Y_Motion + 10'd1;
    unique case (state)
      GROUND: begin
        y_motion_fsm = '0;
        if (jump_req && !top_collide) begin
          state_mot    = RISE;
          y_motion_fsm = JUMP_N;
        end else if (!bottom_collide) begin
          state_mot    = FALL;
          y_motion_fsm = 10'd1;
        end
      end
      RISE: begin
        if (top_collide) begin
          state_mot    = FALL;
          y_motion_fsm = '0;
        end else begin
          y_motion_fsm = y_inc;
          if (!y_inc[9])
            state_mot = FALL;
        end
      end
      FALL: begin
        if (bottom_collide) begin
          state_mot    = GROUND;
          y_motion_fsm = '0;
        end else if ($signed(y_inc) > G_MAX_S)
          y_motion_fsm = G_MAX_S;
        else
          y_motion_fsm = y_inc;
      end
      default: state_mot = FALL;
    endcase
`ifdef CHAR_DOUBLE_JUMP_EN
    // landing in the same tick takes priority over an air jump
    air_jump_use = air_jump && jump_req && !top_collide &&
                   ((state == RISE) || ((state == FALL) && !bottom_collide));
    if (air_jump_use) begin
      state_mot    = RISE;
      y_motion_fsm = JUMP_N;
    end
`endif
    state_next    = state_mot;
    y_motion_next = y_motion_fsm;
    y_sum = $signed({2'b00, Char_Y_Pos}) + $signed({{2{y_motion_fsm[9]}}, y_motion_fsm});
    // the floor acts as ground: park there with zero vertical speed
    if (y_sum >= Y_HI) begin
      y_pos_next    = Y_HI[9:0];
      state_next    = GROUND;
      y_motion_next = '0;
    end else if (y_sum < Y_LO)
      y_pos_next = Y_LO[9:0];
    else
      y_pos_next = y_sum[9:0];
  end

  // Outputs decoded from state
  always_comb begin
    on_ground = (state == GROUND);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_clk_d   <= 1'b0;
      jump_prev     <= 1'b0;
      Char_X_Pos    <= 10'(X_START);
      Char_Y_Pos    <= 10'(Y_START);
      Char_X_Motion <= '0;
      Char_Y_Motion <= '0;
    end else begin
      frame_clk_d <= frame_clk;
      if (tick) begin
        jump_prev     <= w_held;
        Char_X_Pos    <= x_pos_next;
        Char_Y_Pos    <= y_pos_next;
        Char_X_Motion <= x_motion_next;
        Char_Y_Motion <= y_motion_next;
      end
    end
  end

`ifdef CHAR_DOUBLE_JUMP_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      air_jump <= 1'b0;
    else if (tick) begin
      if ((state_next == GROUND) && (state != GROUND))
        air_jump <= 1'b1;
      else if (air_jump_use)
        air_jump <= 1'b0;
    end
  end
`endif

endmodule
